// File: rtl/sdr_req_arb.sv
// -----------------------------------------------------------------------------
// sdr_req_arb
//
// Round-robin arbiter that shares the SDRAM controller's single host request
// port among NREQ masters. The winner's address, direction and burst length
// are latched and presented on u_addr/sdr_req_wr_n/bl for the whole
// transaction. sdr_req is held high from grant until the end of the burst,
// and is then held low for GAP_CYC cycles before the next grant. This gives
// the controller's rising-edge address capture a clean edge.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   init_done           controller initialised; no new grant while low
//   m_req/m_wr_n        per-master request level and direction (0=write)
//   m_addr/m_bl         packed per-master address (AW) and burst length (9)
//   m_gnt               one-hot grant, high from latch to end of transaction
//   m_ack/m_done/m_err  one-cycle per-master pulses: accepted / completed /
//                       ack timeout or illegal burst length
//   sdr_req, sdr_req_wr_n, u_addr, bl   request and latched fields to the controller
//   req_ack, xfer_done  controller accept pulse and end-of-burst pulse
// -----------------------------------------------------------------------------
module sdr_req_arb #(
    parameter int NREQ    = 4,
    parameter int AW      = 23,
    parameter int GAP_CYC = 2,
    parameter int ACK_TMO = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init_done,
    input  logic [NREQ-1:0]      m_req,
    input  logic [NREQ-1:0]      m_wr_n,
    input  logic [NREQ*AW-1:0]   m_addr,
    input  logic [NREQ*9-1:0]    m_bl,
    output logic [NREQ-1:0]      m_gnt,
    output logic [NREQ-1:0]      m_ack,
    output logic [NREQ-1:0]      m_done,
    output logic [NREQ-1:0]      m_err,
    output logic                 sdr_req,
    output logic                 sdr_req_wr_n,
    output logic [AW-1:0]        u_addr,
    output logic [8:0]           bl,
    input  logic                 req_ack,
    input  logic                 xfer_done
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMAX = (ACK_TMO > GAP_CYC) ? ACK_TMO : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_GAP} state_t;

    state_t             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      cur_q;
    logic [TW-1:0]      timer_q;
    logic               sdr_req_q;
    logic               wr_n_q;
    logic [AW-1:0]      addr_q;
    logic [8:0]         bl_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    ack_q;
    logic [NREQ-1:0]    done_q;
    logic [NREQ-1:0]    err_q;

    // Round-robin pick: requests at or above rr_ptr take priority; if there
    // are none, wrap and take the lowest request overall.
    logic [NREQ-1:0]    req_hi;
    logic [NREQ-1:0]    pick_src;
    logic [NREQ-1:0]    win_oh;
    logic [PW-1:0]      win_idx;
    logic               win_vld;
    logic [PW-1:0]      idx_acc [NREQ+1];

    assign req_hi   = m_req & ~((ONE << rr_ptr_q) - ONE);
    assign pick_src = (req_hi != '0) ? req_hi : m_req;
    // Isolate the lowest set bit.
    assign win_oh   = pick_src & (~pick_src + ONE);
    assign win_vld  = |m_req;

    // Per-master field views and a one-hot to index encoder.
    logic [AW-1:0]      addr_arr [NREQ];
    logic [8:0]         bl_arr   [NREQ];

    assign idx_acc[0] = '0;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_master
        assign addr_arr[gi]  = m_addr[gi*AW +: AW];
        assign bl_arr[gi]    = m_bl[gi*9 +: 9];
        assign idx_acc[gi+1] = idx_acc[gi] | (win_oh[gi] ? PW'(gi) : '0);
    end
    assign win_idx = idx_acc[NREQ];

    logic [AW-1:0]      sel_addr;
    logic [8:0]         sel_bl;
    logic               sel_wr_n;
    logic               bl_legal;

    assign sel_addr = addr_arr[win_idx];
    assign sel_bl   = bl_arr[win_idx];
    assign sel_wr_n = m_wr_n[win_idx];

    always_comb begin
        bl_legal = 1'b0;
        case (sel_bl)
            9'd1, 9'd2, 9'd4, 9'd8, 9'd256: bl_legal = 1'b1;
            default:                        bl_legal = 1'b0;
        endcase
    end

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            cur_q     <= '0;
            timer_q   <= '0;
            sdr_req_q <= 1'b0;
            wr_n_q    <= 1'b0;
            addr_q    <= '0;
            bl_q      <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (init_done && win_vld) begin
                        cur_q   <= win_idx;
                        addr_q  <= sel_addr;
                        wr_n_q  <= sel_wr_n;
                        bl_q    <= sel_bl;
                        timer_q <= '0;
                        if (bl_legal) begin
                            gnt_q     <= win_oh;
                            sdr_req_q <= 1'b1;
                            state_q   <= S_REQ;
                        end else begin
                            // Rejected without ever raising sdr_req.
                            err_q    <= win_oh;
                            rr_ptr_q <= ptr_after(win_idx);
                            state_q  <= S_GAP;
                        end
                    end
                end
                S_REQ: begin
                    // An ack on the timeout cycle still wins.
                    if (req_ack) begin
                        ack_q <= ONE << cur_q;
                        if (xfer_done) begin
                            done_q    <= ONE << cur_q;
                            sdr_req_q <= 1'b0;
                            gnt_q     <= '0;
                            rr_ptr_q  <= ptr_after(cur_q);
                            timer_q   <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end else if (timer_q == TW'(ACK_TMO - 1)) begin
                        err_q     <= ONE << cur_q;
                        sdr_req_q <= 1'b0;
                        gnt_q     <= '0;
                        rr_ptr_q  <= ptr_after(cur_q);
                        timer_q   <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_BUSY: begin
                    // sdr_req stays high here: the controller clears its
                    // column counter whenever sdr_req is low.
                    if (xfer_done) begin
                        done_q    <= ONE << cur_q;
                        sdr_req_q <= 1'b0;
                        gnt_q     <= '0;
                        rr_ptr_q  <= ptr_after(cur_q);
                        timer_q   <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (timer_q == TW'(GAP_CYC - 1)) begin
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_gnt        = gnt_q;
    assign m_ack        = ack_q;
    assign m_done       = done_q;
    assign m_err        = err_q;
    assign sdr_req      = sdr_req_q;
    assign sdr_req_wr_n = wr_n_q;
    assign u_addr       = addr_q;
    assign bl           = bl_q;

endmodule

// File: doc/sdr_req_arb.md
Name: sdr_req_arb

Overview:
- Shares the single host request port of the SDRAM/DDR address/command path among NREQ masters (DMA, CPU, video, refresh-test).
- Round-robin arbitration; latches the winner's address, direction and burst length.
- Holds sdr_req high for the whole transaction and enforces an idle gap between transactions, so that the controller's sdr_req rising-edge address capture sees a clean edge.
- Sits between the host bus interfaces and the controller's u_addr/sdr_req/sdr_req_wr_n/bl inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 23, host address width (bank 2 + row 12 + col 9)
GAP_CYC, 2, clk cycles sdr_req held low between transactions (min 1)
ACK_TMO, 64, clk cycles allowed from sdr_req rise to req_ack before abort

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
init_done  in  1  controller initialisation complete; no grant while low
m_req  in  NREQ  per-master request level, held until m_done or m_err
m_wr_n  in  NREQ  per-master direction, 0=write 1=read
m_addr  in  NREQ*AW  packed addresses, master i at [i*AW +: AW]
m_bl  in  NREQ*9  packed burst lengths, master i at [i*9 +: 9]
m_gnt  out  NREQ  one-hot grant, high from latch until end of transaction
m_ack  out  NREQ  one-cycle pulse when controller accepts the request
m_done  out  NREQ  one-cycle pulse at transaction completion
m_err  out  NREQ  one-cycle pulse on ack timeout or illegal bl
sdr_req  out  1  request to controller
sdr_req_wr_n  out  1  latched direction
u_addr  out  AW  latched address
bl  out  9  latched burst length
req_ack  in  1  controller accept pulse
xfer_done  in  1  controller end-of-burst pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE; rr_ptr=0; all outputs 0 (sdr_req, sdr_req_wr_n, u_addr, bl, m_gnt, m_ack, m_done, m_err); timers 0.
- States: IDLE, REQ, BUSY, GAP.
- IDLE:
  - If init_done=1 and m_req!=0, choose the first requesting index searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Latch that master's m_addr, m_wr_n and m_bl into u_addr/sdr_req_wr_n/bl; set m_gnt one-hot.
  - Legal bl values: 1, 2, 4, 8, 256. If bl is illegal: pulse m_err[i] next cycle, leave sdr_req low, set rr_ptr=i+1, go GAP.
  - Otherwise assert sdr_req at the next edge and go REQ. Latency: m_req sampled at edge N gives sdr_req=1 after edge N+1.
- REQ:
  - sdr_req=1 and latched fields stable.
  - Timeout counter counts clk cycles. On req_ack: pulse m_ack[i] and go BUSY.
  - If the counter reaches ACK_TMO with no ack: drop sdr_req, pulse m_err[i], clear m_gnt, set rr_ptr=i+1, go GAP.
- BUSY:
  - sdr_req stays 1, because the controller clears its column counter when sdr_req is low.
  - On xfer_done: drop sdr_req, pulse m_done[i], clear m_gnt, set rr_ptr=i+1, go GAP.
- GAP:
  - sdr_req=0 for exactly GAP_CYC cycles, then IDLE.
  - A new grant's sdr_req rise is therefore at least GAP_CYC+1 cycles after the fall.
- Simultaneous events:
  - req_ack and xfer_done in the same REQ cycle: pulse m_ack and m_done together; go GAP directly.
  - req_ack on the timeout cycle: ack wins, no error.
  - xfer_done while in REQ without ack, or in IDLE/GAP: ignored.
- Master behaviour during a transaction:
  - Deassertion of m_req while granted is ignored; the transaction completes and m_done still pulses.
  - The master re-requests only after m_done or m_err.
  - Changes on unselected m_addr/m_wr_n/m_bl never disturb the latched outputs.
- init_done falling mid-transaction: the current transaction completes normally; no new grant until init_done returns high.
- rr_ptr wraps NREQ-1 to 0. At most one m_gnt bit is ever set. m_ack, m_done and m_err are never high together except in the same-cycle ack+done case.

Test Plan:
- Single master 0, write, addr 23'h12_3456, bl 4; req_ack at cycle 3, xfer_done at cycle 8 -> sdr_req high from cycle 1 to cycle 8; u_addr=23'h123456; sdr_req_wr_n=0; m_ack[0] at cycle 4; m_done[0] at cycle 9; sdr_req low for 2 cycles afterwards.
- All 4 masters requesting continuously, each ack+done 3 cycles after grant -> grant order 0,1,2,3,0; no two gnt bits ever set; each sdr_req rise preceded by >=2 low cycles.
- Master 2 requests and req_ack never arrives -> after 64 cycles sdr_req falls and m_err[2] pulses once; next grant goes to master 3 if it is requesting.
- Master 1 requests with bl=9'd3 -> m_err[1] pulses, sdr_req never rises; master 1 retries with bl=8 -> normal transaction.
- init_done=0 with m_req=4'b0001 -> no grant. Then set init_done=1 -> grant within 1 cycle. Drop init_done during BUSY -> m_done still issued, no further grant.
- reset_n asserted during BUSY -> immediately sdr_req=0, m_gnt=0, u_addr=0. After release with m_req=4'b1010 -> master 1 is granted first (rr_ptr=0).
